// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the Execute stage.
// One radix-2 step per cycle on operand magnitudes, sign fixed up at completion.
module ex_muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_e_i,
    input  logic [2:0]            op_e_i,
    input  logic [DATA_WIDTH-1:0] src_a_e_i,
    input  logic [DATA_WIDTH-1:0] src_b_e_i,
    input  logic                  flush_e_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    op_q;
    logic          neg_q;
    logic [W-1:0]  hi_q, lo_q, b_q;

    // start-time decode
    logic         a_neg, b_neg, a_sgn, b_sgn, neg_d;
    logic [W-1:0] a_mag, b_mag, special_res;
    logic         div_zero, div_ovf;

    always_comb begin
        a_neg = src_a_e_i[W-1];
        b_neg = src_b_e_i[W-1];
        a_sgn = (op_e_i == 3'b001) || (op_e_i == 3'b010) || (op_e_i == 3'b100) || (op_e_i == 3'b110);
        b_sgn = (op_e_i == 3'b001) || (op_e_i == 3'b100) || (op_e_i == 3'b110);
        a_mag = (a_sgn && a_neg) ? -src_a_e_i : src_a_e_i;
        b_mag = (b_sgn && b_neg) ? -src_b_e_i : src_b_e_i;
        case (op_e_i)
            3'b001, 3'b100: neg_d = a_neg ^ b_neg;
            3'b010, 3'b110: neg_d = a_neg;
            default:        neg_d = 1'b0;
        endcase
        div_zero = op_e_i[2] && (src_b_e_i == '0);
        div_ovf  = op_e_i[2] && !op_e_i[0] && (src_a_e_i == {1'b1, {(W-1){1'b0}}})
                   && (src_b_e_i == '1);
        if (div_zero)
            special_res = op_e_i[1] ? src_a_e_i : '1;
        else
            special_res = op_e_i[1] ? '0 : {1'b1, {(W-1){1'b0}}};
    end

    // one iteration: hi holds product-high / partial remainder, lo holds multiplier / quotient
    logic [W:0]     mul_sum, div_sh, div_diff;
    logic [W-1:0]   hi_n, lo_n, quo_f, rem_f, fin;
    logic [2*W-1:0] prod_f;

    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_sh   = {hi_q, lo_q[W-1]};
        div_diff = div_sh - {1'b0, b_q};
        if (op_q[2]) begin
            if (!div_diff[W]) begin
                hi_n = div_diff[W-1:0];
                lo_n = {lo_q[W-2:0], 1'b1};
            end else begin
                hi_n = div_sh[W-1:0];
                lo_n = {lo_q[W-2:0], 1'b0};
            end
        end else begin
            hi_n = mul_sum[W:1];
            lo_n = {mul_sum[0], lo_q[W-1:1]};
        end
        prod_f = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
        quo_f  = neg_q ? -lo_n : lo_n;
        rem_f  = neg_q ? -hi_n : hi_n;
        case (op_q)
            3'b000:                 fin = prod_f[W-1:0];
            3'b001, 3'b010, 3'b011: fin = prod_f[2*W-1:W];
            3'b100, 3'b101:         fin = quo_f;
            default:                fin = rem_f;
        endcase
    end

    assign busy_o = !rst && (((state == IDLE) && start_e_i && !flush_e_i) || (state == CALC));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            done_o   <= 1'b0;
            result_o <= '0;
        end else begin
            done_o <= 1'b0;
            if (flush_e_i) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (start_e_i) begin
                        op_q  <= op_e_i;
                        neg_q <= neg_d;
                        hi_q  <= '0;
                        lo_q  <= a_mag;
                        b_q   <= b_mag;
                        cnt   <= '0;
                        if (div_zero || div_ovf) begin
                            result_o <= special_res;
                            done_o   <= 1'b1;
                            state    <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                    CALC: begin
                        hi_q <= hi_n;
                        lo_q <= lo_n;
                        cnt  <= cnt + CW'(1);
                        if (cnt == CW'(W-1)) begin
                            result_o <= fin;
                            done_o   <= 1'b1;
                            state    <= DONE;
                        end
                    end
                    // start is ignored here: the finishing instruction is still in Execute
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative RV32M multiply/divide unit in the Execute stage. Consumes the operands and control that the ID/EX pipeline register presents to Execute, computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles, and raises a busy/stall request to the hazard unit. While busy, the hazard unit holds the ID/EX register and everything upstream. The unit delivers a one-cycle result strobe that the Execute result mux selects in place of the ALU output.

## Interface
- DATA_WIDTH, `DATA_WIDTH (32): operand/result width; the iteration count equals DATA_WIDTH.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start_e_i  in  1  a valid M-extension instruction is in Execute (from the ID/EX muldiv control bit)
- op_e_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- src_a_e_i  in  DATA_WIDTH  rs1 operand, after forwarding
- src_b_e_i  in  DATA_WIDTH  rs2 operand, after forwarding
- flush_e_i  in  1  abort: the Execute instruction is squashed
- busy_o  out  1  stall request to the hazard unit
- done_o  out  1  result valid for exactly one cycle
- result_o  out  DATA_WIDTH  result; registered; holds its value until the next completion

## Operation
- FSM states: IDLE, CALC, DONE.
- **IDLE**
  - If start_e_i=1 and flush_e_i=0: latch op, operand magnitudes and sign flags, clear the step counter.
  - A special case (see below) goes to DONE. Otherwise go to CALC.
- **CALC**
  - One radix-2 step per cycle.
  - Multiply: shift-add into a 2×DATA_WIDTH accumulator.
  - Divide: restoring shift-subtract producing quotient and remainder.
  - After step DATA_WIDTH-1, go to DONE.
- **DONE**
  - done_o=1 and result_o is valid.
  - Unconditionally return to IDLE. start_e_i is ignored in DONE, because the same instruction is still visible while the pipeline advances.
- **Signed handling**: operate on magnitudes, then negate the final value when required.
  - MULH: product sign = a_neg XOR b_neg.
  - MULHSU: product sign = a_neg.
  - MULHU, DIVU, REMU: never negated.
  - DIV: quotient sign = a_neg XOR b_neg.
  - REM: remainder sign = a_neg.
- **Result select**
  - MUL: low DATA_WIDTH bits of the product.
  - MULH, MULHSU, MULHU: high DATA_WIDTH bits of the signed-corrected 2×DATA_WIDTH product.
- **Special cases**: detected in IDLE at start and skip CALC.
  - Divide by zero: DIV/DIVU return all-ones; REM/REMU return src_a.
  - Signed overflow (DIV/REM with src_a=0x8000_0000 and src_b=0xFFFF_FFFF): DIV returns 0x8000_0000; REM returns 0.
- **busy_o** is combinational and forced to 0 while rst=1:
  - (state==IDLE && start_e_i && !flush_e_i) || state==CALC.
  - busy_o=0 in DONE, so ID/EX and EX/MEM advance on the DONE edge.
- **flush_e_i** has priority over start and over all states. On the next edge the FSM goes to IDLE, done_o stays 0 and result_o is unchanged.
- **rst**: on the next edge state=IDLE, counter=0, result_o=0, done_o=0, accumulators=0. Reset mid-operation discards the operation with no strobe.

## Timing
- Start sampled on edge E0 (cycle C0).
- Normal ops:
  - CALC occupies cycles C1..C32.
  - DONE occurs in C33; done_o is high during C33 only.
  - Total latency: 33 cycles from the start cycle to the strobe; busy_o is high for C0..C32, i.e. 33 cycles.
- Special cases: DONE occurs in C1; busy_o is high in C0 only.
- A back-to-back M instruction can start in the cycle after DONE (C34 at the earliest).
- Operands are latched at E0. Later changes on src_*_e_i are ignored until the next start.
- result_o updates on the edge entering DONE. It is stable from the DONE cycle onward until the next completion.

## Test plan
- MUL 7 × (−3) (src_b=0xFFFF_FFFD) → busy_o high 33 cycles, done_o pulses once at C33, result_o=0xFFFF_FFEB.
- High-half products of 0x8000_0000 and 0xFFFF_FFFF:
  - MULH → 0x0000_0000.
  - MULHU → 0x7FFF_FFFF.
  - MULHSU → 0x8000_0000.
- DIV −7/2 → 0xFFFF_FFFD. REM −7/2 → 0xFFFF_FFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- Special cases:
  - DIVU 5/0 → 0xFFFF_FFFF with done_o at C1.
  - REM 5/0 → 5.
  - DIV 0x8000_0000/−1 → 0x8000_0000 with busy_o for 1 cycle only.
- Abort and reset:
  - flush_e_i asserted at C10 of a DIV → IDLE next cycle, no done_o, result_o unchanged, busy_o low.
  - rst at C20 → all outputs 0 next cycle.
- start_e_i held high through DONE → no second operation starts.
- A new MUL presented at C34 completes normally at C67.
